regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port general register file with an integrated busy scoreboard, for the
//  dual-writeback core. NUM_RD combinational read ports and two writeback ports; r0 is hardwired
//  to zero. Decode uses the per-register busy bits to stall on RAW/WAW hazards against
//  multi-cycle producers (load, mul/div) until the matching writeback clears them.
// PARAMETERS
//  DATA_W    32            register width in bits
//  ADDR_W    5             register address width
//  NUM_REGS  2**ADDR_W     number of registers (r0 constant zero)
//  NUM_RD    2             number of read ports (1..4)
// PORTS
//  clk           in   1                 core clock, all state on rising edge
//  rst           in   1                 asynchronous reset, active-high
//  rd_en_i       in   NUM_RD            per-port read enable
//  rd_addr_i     in   NUM_RD*ADDR_W     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data_o     out  NUM_RD*DATA_W     packed read data
//  rd_busy_o     out  NUM_RD            addressed register has a pending write
//  issue_en_i    in   1                 decode claims a destination for a multi-cycle op
//  issue_addr_i  in   ADDR_W            destination being claimed
//  issue_stall_o out  1                 claim refused; decode must hold and retry
//  wr0_en_i      in   1                 writeback port 0 (ALU) write enable
//  wr0_addr_i    in   ADDR_W            port 0 address
//  wr0_data_i    in   DATA_W            port 0 data
//  wr0_clr_i     in   1                 port 0 write also releases the busy bit
//  wr1_en_i/wr1_addr_i/wr1_data_i/wr1_clr_i   same, writeback port 1 (mem/muldiv)
//  busy_cnt_o    out  ADDR_W+1          number of registers currently busy
// BEHAVIOUR
//  - Reset (async, rst=1): all registers 0, all busy bits 0, busy_cnt_o=0; rd_data_o=0,
//    rd_busy_o=0 and issue_stall_o=0 while rst is high.
//  - Read is combinational, 0-cycle latency. rd_en_i=0 or address 0 -> data 0, busy 0.
//  - Writes commit on the rising edge. Address 0 is ignored (no data write, no busy effect).
//    Same address on both ports in one cycle: port 1 data wins; either clr releases busy.
//  - issue_stall_o = issue_en_i & issue_addr_i!=0 & busy_q[issue_addr_i]. Same-cycle clr of
//    that address does not lift the stall (busy is registered only). Accepted issue sets the
//    busy bit on the next edge. Address 0 is always accepted and never sets busy.
//  - Set and clear of the same address in one cycle (accepted issue plus clr on a non-busy
//    register): set wins, busy=1. A clr on a non-busy register writes data and leaves busy at 0.
//  - busy_cnt_o is registered: +1 per newly set bit, -1 per released bit (net per cycle).
//    It never wraps; the max is NUM_REGS-1.
//  - Reset mid-operation drops all pending claims; in-flight writebacks arriving after reset
//    write data normally but clear nothing.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read matching an enabled same-cycle write gets that write's
//    data (port 1 over port 0). rd_busy_o is forced 0 when the matching write has clr=1.
//  Not defined: reads return stored state only. New data and busy release are visible 1 cycle
//    after the write edge. Decode forwarding is handled in the pipeline.
// STRUCTURE
//  - regfile_pkg: DATA_W/ADDR_W defaults, ZERO_WORD, REG_ZERO address constant.
//  - Sub-module regfile_scoreboard: busy bit vector, set/clear priority, busy_cnt, issue stall.
//  - Top: register array, write logic, generate loop of NUM_RD read muxes.
// TESTING
//  1. Reset, then read r1..r31 on all ports -> all 0, rd_busy_o=0, busy_cnt_o=0.
//  2. Write wr0 r5=0xDEADBEEF, next cycle read r5 -> 0xDEADBEEF. Write r0=0x1 -> read r0=0.
//  3. Same cycle wr0 r7=0x11 and wr1 r7=0x22 -> r7=0x22. With BYPASS_EN, a same-cycle read
//     gives 0x22; without it, the read gives the old value.
//  4. Issue r9 -> busy_cnt=1, rd_busy for r9=1. Issue r9 again -> issue_stall_o=1.
//     wr1 r9 with clr -> busy clears next cycle, cnt=0.
//  5. Issue r3 plus wr0 r4 with clr (r4 not busy) in the same cycle -> cnt=1, r4 written,
//     r4 busy stays 0. Issue r0 -> no stall, cnt unchanged.
//  6. Issue r2 and r6, assert rst asynchronously between clock edges -> busy and cnt are 0
//     immediately, before the next clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-port register file.
//   REGFILE_DATA_W / REGFILE_ADDR_W : default register width and address width.
//   ZERO_WORD                       : all-zero register value (reads of r0 and gated ports).
//   REG_ZERO                        : address of the hardwired zero register.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;

    localparam logic [REGFILE_DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [REGFILE_ADDR_W-1:0] REG_ZERO  = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking multi-cycle producers.
//   clk, rst            : clock, asynchronous active-high reset
//   issue_en_i/addr_i   : decode claims a destination register
//   issue_stall_o       : claim refused because the destination is already busy
//   clr0_en_i/addr_i    : writeback port 0 releases a busy bit
//   clr1_en_i/addr_i    : writeback port 1 releases a busy bit
//   busy_o              : registered busy vector, bit i = register i pending
//   busy_cnt_o          : registered count of busy registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              issue_stall_o,
    input  logic              clr0_en_i,
    input  logic [ADDR_W-1:0] clr0_addr_i,
    input  logic              clr1_en_i,
    input  logic [ADDR_W-1:0] clr1_addr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [ADDR_W:0]   busy_cnt_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [ADDR_W:0]     busy_cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic [1:0]          rel_cnt;
    logic                issue_nz;
    logic                issue_ok;

    assign issue_nz = issue_addr_i != ADDR_W'(REG_ZERO);
    // Stall looks only at the registered busy bit, so a release in the same
    // cycle does not unblock the claim until the following cycle.
    assign issue_ok      = issue_en_i && issue_nz && !busy_q[issue_addr_i];
    assign issue_stall_o = !rst && issue_en_i && issue_nz && busy_q[issue_addr_i];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        rel_cnt = '0;
        if (issue_ok)
            set_vec[issue_addr_i] = 1'b1;
        if (clr0_en_i && clr0_addr_i != ADDR_W'(REG_ZERO))
            clr_vec[clr0_addr_i] = 1'b1;
        if (clr1_en_i && clr1_addr_i != ADDR_W'(REG_ZERO))
            clr_vec[clr1_addr_i] = 1'b1;
        // Only bits that were busy count as releases; a set can only target a
        // non-busy bit, so set and release never overlap in the count.
        for (int i = 0; i < NUM_REGS; i++)
            rel_cnt = rel_cnt + 2'(busy_q[i] & clr_vec[i]);
        cnt_d = busy_cnt_q + (ADDR_W+1)'(issue_ok) - (ADDR_W+1)'(rel_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            // set has priority over a same-cycle clear
            busy_q     <= (busy_q & ~clr_vec) | set_vec;
            busy_cnt_q <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with integrated busy scoreboard.
//   NUM_RD combinational read ports, two writeback ports, r0 hardwired to zero.
//   Optional macro REGFILE_BYPASS_EN: reads see same-cycle writes (port 1 over
//   port 0) and busy is masked when the matching write releases it.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   rd_en_i/rd_addr_i         : per-port read enable / packed addresses
//   rd_data_o/rd_busy_o       : packed read data / addressed register pending
//   issue_en_i/issue_addr_i   : destination claim from decode
//   issue_stall_o             : claim refused, decode retries
//   wr0_*/wr1_*               : writeback ports (en, addr, data, clr)
//   busy_cnt_o                : number of busy registers
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     issue_en_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    output logic                     issue_stall_o,
    input  logic                     wr0_en_i,
    input  logic [ADDR_W-1:0]        wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr0_clr_i,
    input  logic                     wr1_en_i,
    input  logic [ADDR_W-1:0]        wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     wr1_clr_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .issue_en_i    (issue_en_i),
        .issue_addr_i  (issue_addr_i),
        .issue_stall_o (issue_stall_o),
        .clr0_en_i     (wr0_en_i & wr0_clr_i),
        .clr0_addr_i   (wr0_addr_i),
        .clr1_en_i     (wr1_en_i & wr1_clr_i),
        .clr1_addr_i   (wr1_addr_i),
        .busy_o        (busy_q),
        .busy_cnt_o    (busy_cnt_o)
    );

    // Port 1 is assigned last so it wins on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (wr0_en_i && wr0_addr_i != ADDR_W'(REG_ZERO))
                regs[wr0_addr_i] <= wr0_data_i;
            if (wr1_en_i && wr1_addr_i != ADDR_W'(REG_ZERO))
                regs[wr1_addr_i] <= wr1_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = DATA_W'(ZERO_WORD);
            busy = 1'b0;
            if (!rst && rd_en_i[k] && addr != ADDR_W'(REG_ZERO)) begin
                data = regs[addr];
                busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
                if (wr0_en_i && wr0_addr_i == addr) begin
                    data = wr0_data_i;
                    if (wr0_clr_i)
                        busy = 1'b0;
                end
                if (wr1_en_i && wr1_addr_i == addr) begin
                    data = wr1_data_i;
                    if (wr1_clr_i)
                        busy = 1'b0;
                end
`endif
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        assign rd_busy_o[k]                  = busy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_RD-1:0]        rd_en = '0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_en = 1'b0;
    logic [ADDR_W-1:0]        issue_addr = '0;
    logic                     issue_stall;
    logic                     wr0_en = 1'b0, wr0_clr = 1'b0;
    logic [ADDR_W-1:0]        wr0_addr = '0;
    logic [DATA_W-1:0]        wr0_data = '0;
    logic                     wr1_en = 1'b0, wr1_clr = 1'b0;
    logic [ADDR_W-1:0]        wr1_addr = '0;
    logic [DATA_W-1:0]        wr1_data = '0;
    logic [ADDR_W:0]          busy_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] obs_q[$];

    regfile_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .issue_en_i    (issue_en),
        .issue_addr_i  (issue_addr),
        .issue_stall_o (issue_stall),
        .wr0_en_i      (wr0_en),
        .wr0_addr_i    (wr0_addr),
        .wr0_data_i    (wr0_data),
        .wr0_clr_i     (wr0_clr),
        .wr1_en_i      (wr1_en),
        .wr1_addr_i    (wr1_addr),
        .wr1_data_i    (wr1_data),
        .wr1_clr_i     (wr1_clr),
        .busy_cnt_o    (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_addr = '0;
        wr0_en = 1'b0; wr0_clr = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_clr = 1'b0; wr1_addr = '0; wr1_data = '0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    task automatic expect_val(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] v);
        obs_q.push_back(v);
    endtask

    function automatic logic [31:0] p0();
        return rd_data[31:0];
    endfunction
    function automatic logic [31:0] p1();
        return rd_data[63:32];
    endfunction
    function automatic logic [31:0] busy2();
        return 32'(rd_busy);
    endfunction
    function automatic logic [31:0] cnt();
        return 32'(busy_cnt);
    endfunction

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        issue_en = 1'b1; issue_addr = 5'd9;
        set_rd(5'd1, 5'd2);
        tick(); tick();
        expect_val("rst_p0", 32'h0);  observe(p0());
        expect_val("rst_p1", 32'h0);  observe(p1());
        expect_val("rst_busy", 32'h0); observe(busy2());
        expect_val("rst_stall", 32'h0); observe(32'(issue_stall));
        expect_val("rst_cnt", 32'h0); observe(cnt());
        idle();
        rst = 1'b0;
        tick();
        for (int r = 1; r < 32; r++) begin
            set_rd(5'(r), 5'(r));
            #1;
            expect_val($sformatf("init_r%0d_p0", r), 32'h0);   observe(p0());
            expect_val($sformatf("init_r%0d_p1", r), 32'h0);   observe(p1());
            expect_val($sformatf("init_r%0d_busy", r), 32'h0); observe(busy2());
        end
        expect_val("init_cnt", 32'h0); observe(cnt());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e; logic [31:0] o;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        tick(); idle();
        set_rd(5'd5, 5'd5); #1;
        expect_val("wr_r5_p0", 32'hDEADBEEF); observe(p0());
        expect_val("wr_r5_p1", 32'hDEADBEEF); observe(p1());
        rd_en = 2'b01; #1;
        expect_val("rden_off_p1", 32'h0); observe(p1());
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1;
        tick(); idle();
        set_rd(5'd0, 5'd0); #1;
        expect_val("r0_p0", 32'h0); observe(p0());
        expect_val("r0_busy", 32'h0); observe(busy2());
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'hA5A5_0013;
        wr1_en = 1'b1; wr1_addr = 5'd14; wr1_data = 32'h5A5A_0014;
        tick(); idle();
        set_rd(5'd13, 5'd14); #1;
        expect_val("dual_r13", 32'hA5A5_0013); observe(p0());
        expect_val("dual_r14", 32'h5A5A_0014); observe(p1());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_same_addr_write();
        exp_t e; logic [31:0] o;
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h55;
        tick(); idle();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        set_rd(5'd7, 5'd7); #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("coll_samecyc", 32'h22);
`else
        expect_val("coll_samecyc", 32'h55);
`endif
        observe(p0());
        tick(); idle(); #1;
        expect_val("coll_after", 32'h22); observe(p1());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_issue_stall();
        exp_t e; logic [31:0] o;
        issue_en = 1'b1; issue_addr = 5'd9;
        set_rd(5'd9, 5'd1); #1;
        expect_val("iss_first_stall", 32'h0); observe(32'(issue_stall));
        tick(); idle(); #1;
        expect_val("iss_cnt1", 32'h1); observe(cnt());
        expect_val("iss_busy9", 32'h1); observe(busy2());
        issue_en = 1'b1; issue_addr = 5'd9; #1;
        expect_val("iss_again_stall", 32'h1); observe(32'(issue_stall));
        tick(); #1;
        expect_val("iss_stalled_cnt", 32'h1); observe(cnt());
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99; wr1_clr = 1'b1; #1;
        expect_val("iss_clr_stall_held", 32'h1); observe(32'(issue_stall));
`ifdef REGFILE_BYPASS_EN
        expect_val("iss_clr_busy_samecyc", 32'h0);
`else
        expect_val("iss_clr_busy_samecyc", 32'h1);
`endif
        observe(busy2());
        tick(); idle(); #1;
        expect_val("iss_cnt0", 32'h0); observe(cnt());
        expect_val("iss_busy9_clr", 32'h0); observe(busy2());
        expect_val("iss_r9_data", 32'h99); observe(p0());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_set_clr();
        exp_t e; logic [31:0] o;
        issue_en = 1'b1; issue_addr = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44; wr0_clr = 1'b1;
        tick(); idle();
        set_rd(5'd4, 5'd3); #1;
        expect_val("sc_cnt1", 32'h1); observe(cnt());
        expect_val("sc_r4_data", 32'h44); observe(p0());
        expect_val("sc_busy", 32'h2); observe(busy2());
        issue_en = 1'b1; issue_addr = 5'd0; #1;
        expect_val("sc_r0_stall", 32'h0); observe(32'(issue_stall));
        tick(); idle(); #1;
        expect_val("sc_r0_cnt", 32'h1); observe(cnt());
        issue_en = 1'b1; issue_addr = 5'd10; tick();
        issue_addr = 5'd11; tick(); idle(); #1;
        expect_val("sc_cnt3", 32'h3); observe(cnt());
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_clr = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_clr = 1'b1;
        tick(); idle(); #1;
        expect_val("sc_dual_rel_cnt", 32'h1); observe(cnt());
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_clr = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_clr = 1'b1;
        tick(); idle(); #1;
        expect_val("sc_same_rel_cnt", 32'h0); observe(cnt());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e; logic [31:0] o;
        issue_en = 1'b1; issue_addr = 5'd2; tick();
        issue_addr = 5'd6; tick(); idle();
        set_rd(5'd2, 5'd6); #1;
        expect_val("ar_cnt2", 32'h2); observe(cnt());
        expect_val("ar_busy_pre", 32'h3); observe(busy2());
        #1 rst = 1'b1;
        issue_en = 1'b1; issue_addr = 5'd2;
        #1;
        expect_val("ar_cnt_async", 32'h0); observe(cnt());
        expect_val("ar_busy_async", 32'h0); observe(busy2());
        expect_val("ar_stall_async", 32'h0); observe(32'(issue_stall));
        idle();
        #1 rst = 1'b0;
        set_rd(5'd5, 5'd2); #1;
        expect_val("ar_r5_cleared", 32'h0); observe(p0());
        expect_val("ar_busy_post", 32'h0); observe(busy2());
        tick();
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h77; wr1_clr = 1'b1;
        tick(); idle(); #1;
        expect_val("ar_late_wb_data", 32'h77); observe(p1());
        expect_val("ar_late_wb_cnt", 32'h0); observe(cnt());
        issue_en = 1'b1; issue_addr = 5'd2; #1;
        expect_val("ar_reissue_stall", 32'h0); observe(32'(issue_stall));
        tick(); idle(); #1;
        expect_val("ar_reissue_cnt", 32'h1); observe(cnt());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_same_addr_write();
        test_issue_stall();
        test_set_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
